// File: rtl/palette_ram_ctrl_pkg.sv
// ============================================================================
// Module  : palette_ram_ctrl_pkg
// Brief   : Shared widths, read-FSM state and write-buffer entry type for
//           the palette RAM controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package palette_ram_ctrl_pkg;

    localparam int PALETTE_ADDR_W = 15;
    localparam int PALETTE_DATA_W = 16;
    localparam int PALETTE_LANES  = PALETTE_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_REQ  = 2'd1,
        READ_DATA = 2'd2,
        ACK       = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [PALETTE_ADDR_W-1:0] addr;
        logic [PALETTE_DATA_W-1:0] data;
        logic [PALETTE_LANES-1:0]  mask;
    } wbuf_entry_t;

endpackage

`default_nettype wire

// File: rtl/palette_ram_ctrl_if.sv
// ============================================================================
// Module  : palette_ram_ctrl_if
// Brief   : Video read port and CPU req/ack port of the palette RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface palette_ram_ctrl_if
    import palette_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = PALETTE_ADDR_W,
    parameter int DATA_WIDTH = PALETTE_DATA_W
);

    logic                    io_video_rd;
    logic [ADDR_WIDTH-1:0]   io_video_addr;
    logic [DATA_WIDTH-1:0]   io_video_dout;
    logic                    io_cpu_rd;
    logic                    io_cpu_wr;
    logic [ADDR_WIDTH-1:0]   io_cpu_addr;
    logic [DATA_WIDTH-1:0]   io_cpu_din;
    logic [DATA_WIDTH/8-1:0] io_cpu_mask;
    logic [DATA_WIDTH-1:0]   io_cpu_dout;
    logic                    io_cpu_ack;

    modport master (
        output io_video_rd, io_video_addr,
        output io_cpu_rd, io_cpu_wr, io_cpu_addr, io_cpu_din, io_cpu_mask,
        input  io_video_dout, io_cpu_dout, io_cpu_ack
    );

    modport slave (
        input  io_video_rd, io_video_addr,
        input  io_cpu_rd, io_cpu_wr, io_cpu_addr, io_cpu_din, io_cpu_mask,
        output io_video_dout, io_cpu_dout, io_cpu_ack
    );

endinterface

`default_nettype wire

// File: rtl/palette_ram_sp.sv
// ============================================================================
// Module  : palette_ram_sp
// Brief   : Single-port RAM, byte write enables, registered read (block RAM).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_ram_sp #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
) (
    input  wire logic                    clock,
    input  wire logic                    i_en,
    input  wire logic [DATA_WIDTH/8-1:0] i_we,
    input  wire logic [ADDR_WIDTH-1:0]   i_addr,
    input  wire logic [DATA_WIDTH-1:0]   i_din,
    output logic      [DATA_WIDTH-1:0]   o_dout
);

    logic [DATA_WIDTH-1:0] r_mem [1<<ADDR_WIDTH];

    // Read-first: a commit cycle returns the pre-write word, which nobody uses.
    always_ff @(posedge clock) begin
        if (i_en) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_din[b*8 +: 8];
                end
            end
            o_dout <= r_mem[i_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/palette_ram_ctrl.sv
// ============================================================================
// Module  : palette_ram_ctrl
// Brief   : Arbitrates the palette RAM between the video read port (priority)
//           and the CPU port (one-entry write buffer plus read FSM).
//           Optional macro PALETTE_RAM_STARVE_GUARD_EN lets a starved CPU
//           access steal one video slot after STARVE_LIMIT lost cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_ram_ctrl
    import palette_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = PALETTE_ADDR_W,
    parameter int DATA_WIDTH = PALETTE_DATA_W
`ifdef PALETTE_RAM_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 64
`endif
) (
    input  wire logic   clock,
    input  wire logic   reset,
    palette_ram_ctrl_if.slave bus
);

    localparam int c_LANES = DATA_WIDTH / 8;

    rd_state_t             r_state;
    wbuf_entry_t           r_wbuf;
    logic                  r_wbuf_full;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_vid_pend;
    logic [DATA_WIDTH-1:0] r_video_dout;
    logic [DATA_WIDTH-1:0] r_cpu_dout;
    logic                  r_ack;

    logic                  w_steal;
    logic                  w_slot_video;
    logic                  w_slot_commit;
    logic                  w_slot_read;
    logic                  w_wr_accept;
    logic                  w_ram_en;
    logic [c_LANES-1:0]    w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_q;

`ifdef PALETTE_RAM_STARVE_GUARD_EN
    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic               r_starve_cnt_en;
    logic [c_CNT_W-1:0] r_starve_cnt;

    assign r_starve_cnt_en = r_wbuf_full || (r_state == READ_REQ);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_slot_commit || w_slot_read) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt_en && bus.io_video_rd && (r_starve_cnt != c_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_steal = r_starve_cnt_en && (r_starve_cnt == c_LIMIT);
`else
    assign w_steal = 1'b0;
`endif

    // Slot priority: video, then buffered write, then CPU read.
    assign w_slot_video  = bus.io_video_rd && !w_steal;
    assign w_slot_commit = !w_slot_video && r_wbuf_full;
    assign w_slot_read   = !w_slot_video && !r_wbuf_full && (r_state == READ_REQ);
    assign w_wr_accept   = bus.io_cpu_wr && !r_wbuf_full;
    assign w_ram_en      = w_slot_video || w_slot_commit || w_slot_read;
    assign w_ram_we      = w_slot_commit ? r_wbuf.mask : '0;

    always_comb begin
        w_ram_addr = r_rd_addr;
        if (w_slot_video) begin
            w_ram_addr = bus.io_video_addr;
        end else if (w_slot_commit) begin
            w_ram_addr = r_wbuf.addr;
        end
    end

    palette_ram_sp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock  (clock),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_din  (r_wbuf.data),
        .o_dout (w_ram_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wbuf       <= '0;
            r_wbuf_full  <= 1'b0;
            r_rd_addr    <= '0;
            r_vid_pend   <= 1'b0;
            r_video_dout <= '0;
            r_cpu_dout   <= '0;
            r_ack        <= 1'b0;
        end else begin
            r_ack      <= 1'b0;
            r_vid_pend <= w_slot_video;
            if (r_vid_pend) begin
                r_video_dout <= w_ram_q;
            end

            if (w_slot_commit) begin
                r_wbuf_full <= 1'b0;
            end
            if (w_wr_accept) begin
                r_wbuf.addr <= bus.io_cpu_addr;
                r_wbuf.data <= bus.io_cpu_din;
                r_wbuf.mask <= bus.io_cpu_mask;
                r_wbuf_full <= 1'b1;
                r_ack       <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    // A simultaneous write takes this cycle; the read follows.
                    if (bus.io_cpu_rd && !w_wr_accept) begin
                        r_rd_addr <= bus.io_cpu_addr;
                        r_state   <= READ_REQ;
                    end
                end
                READ_REQ: begin
                    if (w_slot_read) begin
                        r_state <= READ_DATA;
                    end
                end
                READ_DATA: begin
                    r_cpu_dout <= w_ram_q;
                    r_ack      <= 1'b1;
                    r_state    <= ACK;
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.io_video_dout = r_video_dout;
    assign bus.io_cpu_dout   = r_cpu_dout;
    assign bus.io_cpu_ack    = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_palette_ram_ctrl.sv
// ============================================================================
// Module  : tb_palette_ram_ctrl
// Brief   : Directed self-checking bench for palette_ram_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_palette_ram_ctrl;
    import palette_ram_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    palette_ram_ctrl_if #(.ADDR_WIDTH(15), .DATA_WIDTH(16)) bus ();

    palette_ram_ctrl #(
        .ADDR_WIDTH (15),
        .DATA_WIDTH (16)
`ifdef PALETTE_RAM_STARVE_GUARD_EN
        ,
        .STARVE_LIMIT (4)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {~b, b};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d,
                             input logic [1:0] m, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        bus.io_cpu_wr   = 1'b1;
        bus.io_cpu_addr = a;
        bus.io_cpu_din  = d;
        bus.io_cpu_mask = m;
        while (!seen && lat < 40) begin
            @(negedge clock);
            lat++;
            seen = bus.io_cpu_ack;
        end
        bus.io_cpu_wr = 1'b0;
        chk("wr_ack_seen", 32'(seen), 32'd1);
    endtask

    task automatic cpu_read(input logic [14:0] a, output logic [15:0] d, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        d    = '0;
        bus.io_cpu_rd   = 1'b1;
        bus.io_cpu_addr = a;
        while (!seen && lat < 40) begin
            @(negedge clock);
            lat++;
            seen = bus.io_cpu_ack;
            if (seen) d = bus.io_cpu_dout;
        end
        bus.io_cpu_rd = 1'b0;
        chk("rd_ack_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        bit          early_ack;
        logic [15:0] sexp [10];

        reset             = 1'b1;
        bus.io_video_rd   = 1'b0;
        bus.io_video_addr = '0;
        bus.io_cpu_rd     = 1'b0;
        bus.io_cpu_wr     = 1'b0;
        bus.io_cpu_addr   = '0;
        bus.io_cpu_din    = '0;
        bus.io_cpu_mask   = '0;
        idle(3);
        chk("rst_video_dout", bus.io_video_dout, 0);
        chk("rst_cpu_dout", bus.io_cpu_dout, 0);
        chk("rst_ack", bus.io_cpu_ack, 0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        reset = 1'b0;
        idle(1);

        // Full-word write then read-back, video idle
        cpu_write(15'h0010, 16'h7FFF, 2'b11, lat);
        chk("wr_lat", lat, 1);
        cpu_read(15'h0010, rd, lat);
        chk("rd_lat", lat, 3);
        chk("rd_0010", rd, 16'h7FFF);
        @(negedge clock);
        chk("ack_one_cycle", bus.io_cpu_ack, 0);

        // Byte lanes
        idle(2);
        cpu_write(15'h0020, 16'h1234, 2'b11, lat);
        idle(2);
        cpu_write(15'h0020, 16'hAB00, 2'b10, lat);
        idle(2);
        cpu_read(15'h0020, rd, lat);
        chk("rd_upper_byte", rd, 16'hAB34);
        idle(2);
        cpu_write(15'h0020, 16'h00CD, 2'b01, lat);
        idle(2);
        cpu_read(15'h0020, rd, lat);
        chk("rd_lower_byte", rd, 16'hABCD);
        idle(2);
        cpu_write(15'h0020, 16'hFFFF, 2'b00, lat);
        chk("mask00_wr_lat", lat, 1);
        idle(2);
        cpu_read(15'h0020, rd, lat);
        chk("rd_mask00", rd, 16'hABCD);

        // Preload 0x00..0xFF for the video sweep
        idle(2);
        for (int i = 0; i < 256; i++) begin
            cpu_write(15'(i), pat(i), 2'b11, lat);
        end
        idle(3);

        // Continuous video strobe with a CPU write stuck in the buffer
        early_ack = 1'b0;
        for (int k = 0; k <= 257; k++) begin
            if (k >= 2) chk($sformatf("vid_%0h", k - 2), bus.io_video_dout, pat(k - 2));
            if (k >= 2 && bus.io_cpu_ack) early_ack = 1'b1;
            if (k == 0) begin
                bus.io_cpu_wr   = 1'b1;
                bus.io_cpu_addr = 15'h0300;
                bus.io_cpu_din  = 16'hBEEF;
                bus.io_cpu_mask = 2'b11;
            end
            if (k == 1) begin
                chk("sweep_wrA_ack", bus.io_cpu_ack, 1);
                bus.io_cpu_wr = 1'b0;
            end
            if (k == 2) begin
                bus.io_cpu_wr   = 1'b1;
                bus.io_cpu_addr = 15'h0301;
                bus.io_cpu_din  = 16'hCAFE;
            end
            if (k <= 255) begin
                bus.io_video_rd   = 1'b1;
                bus.io_video_addr = 15'(k);
            end else begin
                bus.io_video_rd = 1'b0;
            end
            @(negedge clock);
        end
        chk("sweep_no_early_ack", 32'(early_ack), 0);
        chk("sweep_wrB_ack", bus.io_cpu_ack, 1);
        bus.io_cpu_wr = 1'b0;
        chk("vid_hold", bus.io_video_dout, pat(255));
        idle(2);
        cpu_read(15'h0300, rd, lat);
        chk("rd_0300", rd, 16'hBEEF);
        idle(1);
        cpu_read(15'h0301, rd, lat);
        chk("rd_0301", rd, 16'hCAFE);

        // Video and commit to the same address: video returns old data
        idle(2);
        bus.io_cpu_wr     = 1'b1;
        bus.io_cpu_addr   = 15'h0050;
        bus.io_cpu_din    = 16'h0A0A;
        bus.io_cpu_mask   = 2'b11;
        bus.io_video_rd   = 1'b1;
        bus.io_video_addr = 15'h0050;
        @(negedge clock);
        chk("conf_ack", bus.io_cpu_ack, 1);
        bus.io_cpu_wr = 1'b0;
        @(negedge clock);
        chk("conf_old1", bus.io_video_dout, pat(8'h50));
        chk("conf_buf_held", 32'(dut.r_wbuf_full), 1);
        bus.io_video_rd = 1'b0;
        @(negedge clock);
        chk("conf_old2", bus.io_video_dout, pat(8'h50));
        chk("conf_buf_drained", 32'(dut.r_wbuf_full), 0);
        bus.io_video_rd = 1'b1;
        @(negedge clock);
        bus.io_video_rd = 1'b0;
        @(negedge clock);
        chk("conf_new", bus.io_video_dout, 16'h0A0A);

        // Simultaneous read and write: write acked first
        idle(2);
        bus.io_cpu_rd   = 1'b1;
        bus.io_cpu_wr   = 1'b1;
        bus.io_cpu_addr = 15'h0030;
        bus.io_cpu_din  = 16'h5555;
        bus.io_cpu_mask = 2'b11;
        @(negedge clock);
        chk("both_wr_ack", bus.io_cpu_ack, 1);
        bus.io_cpu_wr = 1'b0;
        cpu_read(15'h0030, rd, lat);
        chk("both_rd_lat", lat, 3);
        chk("both_rd_data", rd, 16'h5555);

        // Reset while the read FSM sits in READ_DATA
        idle(2);
        bus.io_cpu_rd   = 1'b1;
        bus.io_cpu_addr = 15'h0030;
        idle(2);
        chk("mid_state", 32'(dut.r_state), 32'(READ_DATA));
        reset         = 1'b1;
        bus.io_cpu_rd = 1'b0;
        @(negedge clock);
        chk("mid_rst_ack", bus.io_cpu_ack, 0);
        chk("mid_rst_cpu_dout", bus.io_cpu_dout, 0);
        chk("mid_rst_video_dout", bus.io_video_dout, 0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        reset = 1'b0;
        @(negedge clock);
        chk("mid_no_late_ack", bus.io_cpu_ack, 0);

        // Reset discards a buffered write
        idle(1);
        bus.io_video_rd   = 1'b1;
        bus.io_video_addr = 15'h0000;
        bus.io_cpu_wr     = 1'b1;
        bus.io_cpu_addr   = 15'h0040;
        bus.io_cpu_din    = 16'hDEAD;
        bus.io_cpu_mask   = 2'b11;
        @(negedge clock);
        chk("disc_ack", bus.io_cpu_ack, 1);
        bus.io_cpu_wr = 1'b0;
        reset         = 1'b1;
        @(negedge clock);
        reset           = 1'b0;
        bus.io_video_rd = 1'b0;
        chk("disc_buf_empty", 32'(dut.r_wbuf_full), 0);
        idle(2);
        cpu_read(15'h0040, rd, lat);
        chk("disc_rd_0040", rd, pat(8'h40));

`ifdef PALETTE_RAM_STARVE_GUARD_EN
        // Starve guard with limit 4: commit steals the 5th contended slot
        for (int k = 2; k <= 9; k++) sexp[k] = pat(8'h60 + k - 2);
        sexp[7] = pat(8'h64);
        idle(2);
        for (int k = 0; k <= 9; k++) begin
            if (k >= 2) chk($sformatf("starve_vid_%0d", k), bus.io_video_dout, sexp[k]);
            if (k == 0) begin
                bus.io_cpu_wr   = 1'b1;
                bus.io_cpu_addr = 15'h0310;
                bus.io_cpu_din  = 16'h1357;
                bus.io_cpu_mask = 2'b11;
            end
            if (k == 1) begin
                chk("starve_ack", bus.io_cpu_ack, 1);
                bus.io_cpu_wr = 1'b0;
            end
            if (k == 5) chk("starve_buf_full", 32'(dut.r_wbuf_full), 1);
            if (k == 6) chk("starve_buf_committed", 32'(dut.r_wbuf_full), 0);
            bus.io_video_rd   = 1'b1;
            bus.io_video_addr = 15'(8'h60 + k);
            @(negedge clock);
        end
        bus.io_video_rd = 1'b0;
        idle(2);
        cpu_read(15'h0310, rd, lat);
        chk("starve_rd_0310", rd, 16'h1357);
`else
        sexp[0] = '0;
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
